cam_kv_table: RTL and testbench



---
 rtl/cam_kv_table.sv | 240 ++++++++++++++++++++++++
 tb/tb_cam_kv_table.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cam_kv_table.sv
// cam_kv_table: key/value CAM with FIFO-buffered update and lookup streams,
// free-slot allocation, delete, and drop-or-evict handling when the table is full.
module cam_kv_fifo #(
   parameter int W = 8,
   parameter int D = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                push,
   input  logic [W-1:0]        din,
   input  logic                pop,
   output logic [W-1:0]        dout,
   output logic [$clog2(D):0]  count
);
   localparam int AW = $clog2(D);
   logic [W-1:0]  mem_q [D];
   logic [W-1:0]  mem_d [D];
   logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
   logic [AW:0]   cnt_q, cnt_d;
   always_comb begin
      mem_d = mem_q;
      if (push) mem_d[wr_q] = din;
      wr_d  = wr_q + AW'(push);
      rd_d  = rd_q + AW'(pop);
      cnt_d = cnt_q + (AW+1)'(push) - (AW+1)'(pop);
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         mem_q <= '{default: '0};
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         mem_q <= mem_d;
         wr_q  <= wr_d;
         rd_q  <= rd_d;
         cnt_q <= cnt_d;
      end
   end
   assign dout  = mem_q[rd_q];
   assign count = cnt_q;
endmodule

module cam_kv_table #(
   parameter int TABLE_SIZE        = 16,
   parameter int KEY_SIZE          = 8,
   parameter int VALUE_SIZE        = 32,
   parameter int UPDATE_USER_WIDTH = 4,
   parameter int LOOKUP_USER_WIDTH = 4,
   parameter int FIFO_DEPTH        = 4,
   parameter int EVICT_ON_FULL     = 0
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic                               s_update_req_op,
   input  logic [KEY_SIZE-1:0]                s_update_req_index,
   input  logic [VALUE_SIZE-1:0]              s_update_req_data,
   input  logic [UPDATE_USER_WIDTH-1:0]       s_update_req_user,
   input  logic                               s_update_req_valid,
   output logic                               s_update_req_ready,
   input  logic [KEY_SIZE-1:0]                s_lookup_req_index,
   input  logic [LOOKUP_USER_WIDTH-1:0]       s_lookup_req_user,
   input  logic                               s_lookup_req_valid,
   output logic                               s_lookup_req_ready,
   output logic [VALUE_SIZE-1:0]              m_lookup_value_data,
   output logic                               m_lookup_value_hit,
   output logic [LOOKUP_USER_WIDTH-1:0]       m_lookup_value_user,
   output logic                               m_lookup_value_valid,
   input  logic                               m_lookup_value_ready,
   output logic [$clog2(TABLE_SIZE+1)-1:0]    occupancy,
   output logic                               update_drop,
   output logic                               update_evict
);
   localparam int TW = $clog2(TABLE_SIZE);
   localparam int OW = $clog2(TABLE_SIZE + 1);
   localparam int FAW = $clog2(FIFO_DEPTH);
   localparam int UW = 1 + KEY_SIZE + VALUE_SIZE + UPDATE_USER_WIDTH;
   localparam int LW = KEY_SIZE + LOOKUP_USER_WIDTH;
   localparam int RW = VALUE_SIZE + 1 + LOOKUP_USER_WIDTH;
   localparam logic [FAW:0] DEPTH = (FAW+1)'(FIFO_DEPTH);

   logic [UW-1:0]                u_dout;
   logic [FAW:0]                 u_count;
   logic                         u_pop;
   logic                         u_op;
   logic [KEY_SIZE-1:0]          u_key;
   logic [VALUE_SIZE-1:0]        u_val;
   logic [UPDATE_USER_WIDTH-1:0] upd_user_unused;
   logic [LW-1:0]                l_dout;
   logic [FAW:0]                 l_count;
   logic                         l_pop;
   logic [KEY_SIZE-1:0]          l_key;
   logic [LOOKUP_USER_WIDTH-1:0] l_user;
   logic                         l_hit;
   logic [VALUE_SIZE-1:0]        l_val;
   logic [RW-1:0]                o_dout;
   logic [FAW:0]                 o_count;
   logic                         o_push, o_pop, o_has, load;

   logic [TABLE_SIZE-1:0]        valid_q, valid_d;
   logic [KEY_SIZE-1:0]          key_q [TABLE_SIZE];
   logic [KEY_SIZE-1:0]          key_d [TABLE_SIZE];
   logic [VALUE_SIZE-1:0]        val_q [TABLE_SIZE];
   logic [VALUE_SIZE-1:0]        val_d [TABLE_SIZE];
   logic [TW-1:0]                victim_q, victim_d;
   logic [OW-1:0]                occ_q, occ_d;
   logic                         drop_q, drop_d, evict_q, evict_d;
   logic                         u_hit, u_free;
   logic [TW-1:0]                u_idx, free_idx;
   logic                         pipe_v_q, pipe_v_d;
   logic [RW-1:0]                pipe_q, pipe_d;
   logic                         m_v_q, m_v_d;
   logic [RW-1:0]                m_res_q, m_res_d;

   assign s_update_req_ready = u_count < DEPTH;
   assign s_lookup_req_ready = l_count < DEPTH;

   cam_kv_fifo #(.W(UW), .D(FIFO_DEPTH)) u_fifo (
      .clk(clk), .rst(rst),
      .push(s_update_req_valid && s_update_req_ready),
      .din({s_update_req_op, s_update_req_index, s_update_req_data, s_update_req_user}),
      .pop(u_pop), .dout(u_dout), .count(u_count)
   );
   cam_kv_fifo #(.W(LW), .D(FIFO_DEPTH)) l_fifo (
      .clk(clk), .rst(rst),
      .push(s_lookup_req_valid && s_lookup_req_ready),
      .din({s_lookup_req_index, s_lookup_req_user}),
      .pop(l_pop), .dout(l_dout), .count(l_count)
   );
   cam_kv_fifo #(.W(RW), .D(FIFO_DEPTH)) o_fifo (
      .clk(clk), .rst(rst),
      .push(o_push), .din(pipe_q),
      .pop(o_pop), .dout(o_dout), .count(o_count)
   );

   assign {u_op, u_key, u_val, upd_user_unused} = u_dout;
   assign {l_key, l_user} = l_dout;
   assign u_pop = u_count != '0;

   // Descending scan leaves the lowest-index free slot in free_idx.
   always_comb begin
      u_hit    = 1'b0;
      u_idx    = '0;
      u_free   = 1'b0;
      free_idx = '0;
      for (int i = TABLE_SIZE - 1; i >= 0; i--) begin
         if (valid_q[i] && key_q[i] == u_key) begin
            u_hit = 1'b1;
            u_idx = TW'(i);
         end
         if (!valid_q[i]) begin
            u_free   = 1'b1;
            free_idx = TW'(i);
         end
      end
      valid_d  = valid_q;
      key_d    = key_q;
      val_d    = val_q;
      victim_d = victim_q;
      occ_d    = occ_q;
      drop_d   = 1'b0;
      evict_d  = 1'b0;
      if (u_pop && u_op && u_hit) begin
         valid_d[u_idx] = 1'b0;
         occ_d          = occ_q - OW'(1);
      end else if (u_pop && !u_op && u_hit) begin
         val_d[u_idx] = u_val;
      end else if (u_pop && !u_op && u_free) begin
         valid_d[free_idx] = 1'b1;
         key_d[free_idx]   = u_key;
         val_d[free_idx]   = u_val;
         occ_d             = occ_q + OW'(1);
      end else if (u_pop && !u_op && EVICT_ON_FULL != 0) begin
         key_d[victim_q] = u_key;
         val_d[victim_q] = u_val;
         evict_d         = 1'b1;
         victim_d        = (victim_q == TW'(TABLE_SIZE - 1)) ? '0 : victim_q + TW'(1);
      end else begin
         drop_d = u_pop && !u_op;
      end
   end

   // Lookups only enter the pipe when the output FIFO can absorb everything in flight.
   always_comb begin
      l_hit = 1'b0;
      l_val = '0;
      for (int i = 0; i < TABLE_SIZE; i++) begin
         if (valid_q[i] && key_q[i] == l_key) begin
            l_hit = 1'b1;
            l_val = val_q[i];
         end
      end
      l_pop    = (l_count != '0) && ((o_count + (FAW+1)'(pipe_v_q)) < DEPTH);
      pipe_v_d = l_pop;
      pipe_d   = l_pop ? {l_val, l_hit, l_user} : pipe_q;
   end

   always_comb begin
      load    = !m_v_q || m_lookup_value_ready;
      o_has   = o_count != '0;
      o_pop   = load && o_has;
      o_push  = pipe_v_q && !(load && !o_has);
      m_v_d   = load ? (o_has || pipe_v_q) : m_v_q;
      m_res_d = !load ? m_res_q : o_has ? o_dout : pipe_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q  <= '0;
         key_q    <= '{default: '0};
         val_q    <= '{default: '0};
         victim_q <= '0;
         occ_q    <= '0;
         drop_q   <= 1'b0;
         evict_q  <= 1'b0;
         pipe_v_q <= 1'b0;
         pipe_q   <= '0;
         m_v_q    <= 1'b0;
         m_res_q  <= '0;
      end else begin
         valid_q  <= valid_d;
         key_q    <= key_d;
         val_q    <= val_d;
         victim_q <= victim_d;
         occ_q    <= occ_d;
         drop_q   <= drop_d;
         evict_q  <= evict_d;
         pipe_v_q <= pipe_v_d;
         pipe_q   <= pipe_d;
         m_v_q    <= m_v_d;
         m_res_q  <= m_res_d;
      end
   end

   assign {m_lookup_value_data, m_lookup_value_hit, m_lookup_value_user} = m_res_q;
   assign m_lookup_value_valid = m_v_q;
   assign occupancy            = occ_q;
   assign update_drop          = drop_q;
   assign update_evict         = evict_q;
endmodule

// File: tb/tb_cam_kv_table.sv
// tb_cam_kv_table: drives a drop-policy and an evict-policy table with identical
// streams and checks both against a slot-level reference model.
module tb_cam_kv_table;
   localparam int TS = 4;
   logic        clk = 1'b0;
   logic        rst;
   always #5 clk = ~clk;

   logic        u_valid, u_op, l_valid, m_ready, l_acc, rand_ready, hv;
   logic [7:0]  u_key, l_key;
   logic [31:0] u_data;
   logic [3:0]  u_user, l_user;
   logic        u_ready [2];
   logic        l_ready [2];
   logic [31:0] o_data [2];
   logic        o_hit [2];
   logic [3:0]  o_user [2];
   logic        o_valid [2];
   logic [2:0]  occ [2];
   logic        drop [2];
   logic        evict [2];
   logic [36:0] hr [2];

   for (genvar g = 0; g < 2; g++) begin : g_dut
      cam_kv_table #(.TABLE_SIZE(TS), .FIFO_DEPTH(4), .EVICT_ON_FULL(g)) dut (
         .clk(clk), .rst(rst),
         .s_update_req_op(u_op), .s_update_req_index(u_key), .s_update_req_data(u_data),
         .s_update_req_user(u_user), .s_update_req_valid(u_valid), .s_update_req_ready(u_ready[g]),
         .s_lookup_req_index(l_key), .s_lookup_req_user(l_user), .s_lookup_req_valid(l_valid),
         .s_lookup_req_ready(l_ready[g]),
         .m_lookup_value_data(o_data[g]), .m_lookup_value_hit(o_hit[g]), .m_lookup_value_user(o_user[g]),
         .m_lookup_value_valid(o_valid[g]), .m_lookup_value_ready(m_ready),
         .occupancy(occ[g]), .update_drop(drop[g]), .update_evict(evict[g])
      );
   end

   int          n_cmp = 0, n_err = 0;
   bit          mv [2][TS];
   logic [7:0]  mk [2][TS];
   logic [31:0] mval [2][TS];
   int          vic;
   int          exp_drop [2], exp_evict [2], obs_drop [2], obs_evict [2];
   logic [36:0] q0 [$], q1 [$];

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] want);
      n_cmp++;
      assert (obs === want) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
      end
   endtask

   function automatic logic [36:0] res(input int d);
      return {o_data[d], o_hit[d], o_user[d]};
   endfunction

   function automatic logic [36:0] model_lk(input int d, input logic [7:0] k, input logic [3:0] u);
      for (int s = 0; s < TS; s++)
         if (mv[d][s] && mk[d][s] == k) return {mval[d][s], 1'b1, u};
      return {32'h0, 1'b0, u};
   endfunction

   function automatic int model_occ(input int d);
      int n;
      n = 0;
      for (int s = 0; s < TS; s++) n += int'(mv[d][s]);
      return n;
   endfunction

   function automatic void model_upd(input logic op, input logic [7:0] k, input logic [31:0] v);
      for (int d = 0; d < 2; d++) begin
         int h, f;
         h = -1;
         f = -1;
         for (int s = TS - 1; s >= 0; s--) begin
            if (mv[d][s] && mk[d][s] == k) h = s;
            if (!mv[d][s]) f = s;
         end
         if (op) begin
            if (h >= 0) mv[d][h] = 1'b0;
         end else if (h >= 0) mval[d][h] = v;
         else if (f >= 0) begin
            mv[d][f] = 1'b1;
            mk[d][f] = k;
            mval[d][f] = v;
         end else if (d == 1) begin
            mk[1][vic] = k;
            mval[1][vic] = v;
            exp_evict[1]++;
            vic = (vic + 1) % TS;
         end else exp_drop[0]++;
      end
   endfunction

   // Scoreboard, output-hold and pulse counting, sampled on the falling edge.
   always @(negedge clk) begin
      if (rst) hv = 1'b0;
      else begin
         for (int d = 0; d < 2; d++) begin
            if (hv) begin
               chk($sformatf("hold_valid%0d", d), o_valid[d], 1);
               chk($sformatf("hold_data%0d", d), res(d), hr[d]);
            end
            obs_drop[d]  += int'(drop[d]);
            obs_evict[d] += int'(evict[d]);
            hr[d] = res(d);
         end
         if (o_valid[0] && m_ready) begin
            chk("res_avail", q0.size() != 0, 1);
            chk("valid1", o_valid[1], 1);
            if (q0.size() != 0) begin
               chk("res0", res(0), q0.pop_front());
               chk("res1", res(1), q1.pop_front());
            end
         end
         hv = o_valid[0] && !m_ready;
      end
   end

   task automatic cyc(input logic uv, input logic op, input logic [7:0] uk, input logic [31:0] ud,
                      input logic lv, input logic [7:0] lk, input logic [3:0] lu);
      u_valid = uv; u_op = op; u_key = uk; u_data = ud; u_user = 4'($urandom);
      l_valid = lv; l_key = lk; l_user = lu;
      l_acc = lv && l_ready[0];
      if (l_acc) begin
         q0.push_back(model_lk(0, lk, lu));
         q1.push_back(model_lk(1, lk, lu));
      end
      if (uv && u_ready[0]) model_upd(op, uk, ud);
      @(posedge clk);
      #1;
      u_valid = 1'b0;
      l_valid = 1'b0;
      if (rand_ready) m_ready = 1'($urandom);
   endtask

   task automatic idle(input int n);
      repeat (n) cyc(0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic wr(input logic [7:0] k, input logic [31:0] v);
      cyc(1, 0, k, v, 0, 0, 0);
   endtask

   task automatic del(input logic [7:0] k);
      cyc(1, 1, k, 32'($urandom), 0, 0, 0);
   endtask

   task automatic lk(input logic [7:0] k, input logic [3:0] u);
      cyc(0, 0, 0, 0, 1, k, u);
   endtask

   task automatic drain(input string tag);
      for (int i = 0; i < 300 && q0.size() != 0; i++) idle(1);
      chk(tag, q0.size(), 0);
   endtask

   task automatic check_state(input string tag);
      for (int d = 0; d < 2; d++) begin
         chk($sformatf("%s_occ%0d", tag, d), occ[d], model_occ(d));
         chk($sformatf("%s_drop%0d", tag, d), obs_drop[d], exp_drop[d]);
         chk($sformatf("%s_evict%0d", tag, d), obs_evict[d], exp_evict[d]);
      end
   endtask

   task automatic do_reset();
      rst = 1'b1; u_valid = 1'b0; l_valid = 1'b0; m_ready = 1'b1; rand_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      for (int d = 0; d < 2; d++) begin
         for (int s = 0; s < TS; s++) mv[d][s] = 1'b0;
         exp_drop[d] = 0; exp_evict[d] = 0; obs_drop[d] = 0; obs_evict[d] = 0;
      end
      vic = 0;
      q0.delete();
      q1.delete();
      rst = 1'b0;
   endtask

   initial begin
      #500000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int acc;
      u_op = 0; u_key = 0; u_data = 0; u_user = 0; l_key = 0; l_user = 0;
      do_reset();
      for (int d = 0; d < 2; d++) begin
         chk($sformatf("rst_uready%0d", d), u_ready[d], 1);
         chk($sformatf("rst_lready%0d", d), l_ready[d], 1);
         chk($sformatf("rst_valid%0d", d), o_valid[d], 0);
         chk($sformatf("rst_occ%0d", d), occ[d], 0);
         chk($sformatf("rst_drop%0d", d), drop[d], 0);
         chk($sformatf("rst_evict%0d", d), evict[d], 0);
      end
      lk(8'h55, 4'h3);
      drain("empty_miss");
      wr(8'h12, 32'hDEADBEEF);
      idle(2);
      lk(8'h12, 4'h5);
      idle(1);
      chk("lat_n2", o_valid[0], 0);
      idle(1);
      chk("lat_n3", o_valid[0], 1);
      drain("first_hit");
      check_state("t1");
      wr(8'h12, 32'h1);
      wr(8'h12, 32'h2);
      idle(2);
      lk(8'h12, 4'hA);
      drain("overwrite");
      check_state("t2");

      do_reset();
      for (int k = 1; k <= 6; k++) wr(8'(k), 32'h100 + 32'(k));
      idle(3);
      check_state("full");
      lk(8'd1, 4'h1); lk(8'd5, 4'h2); lk(8'd6, 4'h3); lk(8'd4, 4'h4);
      drain("full_lk");

      do_reset();
      wr(8'd1, 32'h11); wr(8'd2, 32'h22); wr(8'd3, 32'h33);
      del(8'd2);
      idle(3);
      check_state("del");
      wr(8'd9, 32'h99);
      idle(3);
      check_state("refill");
      del(8'd7);
      idle(3);
      check_state("del_miss");
      wr(8'd10, 32'hAA); wr(8'd11, 32'hBB); wr(8'd12, 32'hCC);
      idle(2);
      lk(8'd9, 4'h9); lk(8'd1, 4'h1); lk(8'd11, 4'hB); lk(8'd12, 4'hC); lk(8'd3, 4'h3);
      drain("slot_lk");
      check_state("slot");

      do_reset();
      for (int i = 0; i < 400; i++)
         cyc(1'($urandom_range(0, 9) < 6), 1'($urandom_range(0, 3) == 0), 8'($urandom_range(0, 7)),
             $urandom, 1'($urandom_range(0, 9) < 6), 8'($urandom_range(0, 7)), 4'($urandom));
      idle(3);
      drain("rand_drain");
      check_state("rand");

      do_reset();
      wr(8'd1, 32'hA1); wr(8'd2, 32'hA2); wr(8'd3, 32'hA3);
      idle(3);
      m_ready = 1'b0;
      acc = 0;
      for (int i = 0; i < 20; i++) begin
         cyc(1'(i == 5), 0, 8'hEE, 32'hE0E0, 1'(acc < 12), 8'($urandom_range(0, 7)), 4'($urandom));
         acc += int'(l_acc);
      end
      chk("bp_accepts", acc, 9);
      chk("bp_lready", l_ready[0], 0);
      chk("bp_uready", u_ready[0], 1);
      check_state("bp");
      rand_ready = 1'b1;
      for (int i = 0; i < 300 && (acc < 12 || q0.size() != 0); i++) begin
         cyc(0, 0, 0, 0, 1'(acc < 12), 8'($urandom_range(0, 7)), 4'($urandom));
         acc += int'(l_acc);
      end
      chk("bp_total", acc, 12);
      chk("bp_drain", q0.size(), 0);
      rand_ready = 1'b0;

      m_ready = 1'b0;
      for (int i = 0; i < 6; i++) lk(8'($urandom_range(0, 7)), 4'($urandom));
      do_reset();
      for (int i = 0; i < 8; i++) begin
         idle(1);
         chk("mid_rst_valid0", o_valid[0], 0);
         chk("mid_rst_valid1", o_valid[1], 0);
      end
      check_state("mid_rst");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
